// File: rtl/sprite_pkg.sv
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared slot attribute types and defaults for the sprite colour mapper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

   localparam int SPR_COORD_W = 10;
   localparam int SPR_COLOR_W = 4;

   typedef logic [3*SPR_COLOR_W-1:0] rgb_t;

   typedef struct packed {
      logic [SPR_COORD_W-1:0] x;
      logic [SPR_COORD_W-1:0] y;
      logic [SPR_COORD_W-1:0] w;
      logic [SPR_COORD_W-1:0] h;
      rgb_t                   color;
      logic                   enable;
      logic                   blink;
   } sprite_attr_t;

   localparam sprite_attr_t SPRITE_ATTR_RESET = '0;

endpackage

`default_nettype wire

// File: rtl/sprite_hit.sv
// ============================================================================
// Module   : sprite_hit
// Purpose  : Combinational coverage test of one pixel against one sprite slot.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_hit
   import sprite_pkg::*;
(
   input  sprite_attr_t           i_attr,
   input  logic [SPR_COORD_W-1:0] i_x,
   input  logic [SPR_COORD_W-1:0] i_y,
   input  logic                   i_blink_phase,
   output logic                   o_hit
);

   // One extra bit keeps the far edge from wrapping, so sprites clip at the screen edge.
   logic [SPR_COORD_W:0] w_x_end;
   logic [SPR_COORD_W:0] w_y_end;
   logic                 w_in_x;
   logic                 w_in_y;
   logic                 w_shown;

   assign w_x_end = {1'b0, i_attr.x} + {1'b0, i_attr.w};
   assign w_y_end = {1'b0, i_attr.y} + {1'b0, i_attr.h};

   assign w_in_x  = (i_x >= i_attr.x) && ({1'b0, i_x} < w_x_end);
   assign w_in_y  = (i_y >= i_attr.y) && ({1'b0, i_y} < w_y_end);
   assign w_shown = i_attr.enable && !(i_attr.blink && i_blink_phase);

   assign o_hit   = w_shown && w_in_x && w_in_y;

endmodule

`default_nettype wire

// File: rtl/sprite_color_mapper.sv
// ============================================================================
// Module   : sprite_color_mapper
// Purpose  : Multi-sprite priority colour mapper, double-buffered slots, 2-cycle pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_color_mapper
   import sprite_pkg::*;
#(
   parameter int                   NUM_SPRITES = 8,
   parameter int                   COORD_W     = SPR_COORD_W,
   parameter int                   COLOR_W     = SPR_COLOR_W,
   parameter int                   BLINK_LOG2  = 5,
   parameter logic [3*COLOR_W-1:0] BG_RGB      = 12'hF00,
   localparam int                  IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
)
(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_start,
   input  logic                   pix_valid,
   input  logic [COORD_W-1:0]     DrawX,
   input  logic [COORD_W-1:0]     DrawY,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [COORD_W-1:0]     wr_x,
   input  logic [COORD_W-1:0]     wr_y,
   input  logic [COORD_W-1:0]     wr_w,
   input  logic [COORD_W-1:0]     wr_h,
   input  logic [3*COLOR_W-1:0]   wr_color,
   input  logic                   wr_enable,
   input  logic                   wr_blink,
   output logic [COLOR_W-1:0]     Red,
   output logic [COLOR_W-1:0]     Green,
   output logic [COLOR_W-1:0]     Blue,
   output logic                   rgb_valid,
   output logic                   hit_any,
   output logic [IDX_W-1:0]       hit_idx
);

   // Slot storage is sized by the package; COORD_W/COLOR_W must match it.
   sprite_attr_t            r_active [NUM_SPRITES];
   sprite_attr_t            w_wr_attr;
   logic                    w_wr_ok;

   logic [BLINK_LOG2-1:0]   r_frame_cnt;
   logic                    w_blink_phase;

   logic [COORD_W-1:0]      r_s1_x;
   logic [COORD_W-1:0]      r_s1_y;
   logic                    r_s1_valid;

   logic [NUM_SPRITES-1:0]  w_hit;
   logic                    w_hit_any;
   logic [IDX_W-1:0]        w_hit_idx;
   logic [3*COLOR_W-1:0]    w_hit_color;

   logic [3*COLOR_W-1:0]    r_rgb;
   logic                    r_rgb_valid;
   logic                    r_hit_any;
   logic [IDX_W-1:0]        r_hit_idx;

   assign w_wr_attr = '{x: wr_x, y: wr_y, w: wr_w, h: wr_h,
                        color: wr_color, enable: wr_enable, blink: wr_blink};
   assign w_wr_ok       = wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(NUM_SPRITES));
   assign w_blink_phase = r_frame_cnt[BLINK_LOG2-1];

   generate
      for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
         sprite_attr_t r_shadow;
         logic         w_sel;

         assign w_sel = w_wr_ok && (wr_idx == IDX_W'(gi));

         // A write coinciding with frame_start is forwarded straight into the active bank.
         always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
               r_shadow     <= SPRITE_ATTR_RESET;
               r_active[gi] <= SPRITE_ATTR_RESET;
            end else begin
               if (w_sel) begin
                  r_shadow <= w_wr_attr;
               end
               if (frame_start) begin
                  r_active[gi] <= w_sel ? w_wr_attr : r_shadow;
               end
            end
         end

         sprite_hit u_hit (
            .i_attr        (r_active[gi]),
            .i_x           (r_s1_x),
            .i_y           (r_s1_y),
            .i_blink_phase (w_blink_phase),
            .o_hit         (w_hit[gi])
         );
      end
   endgenerate

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_frame_cnt <= '0;
      end else if (frame_start) begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

   // Scan from the lowest priority upward so slot 0 is written last and wins.
   always_comb begin
      w_hit_any   = 1'b0;
      w_hit_idx   = '0;
      w_hit_color = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_hit_any   = 1'b1;
            w_hit_idx   = IDX_W'(i);
            w_hit_color = r_active[i].color;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_s1_x      <= '0;
         r_s1_y      <= '0;
         r_s1_valid  <= 1'b0;
         r_rgb       <= '0;
         r_rgb_valid <= 1'b0;
         r_hit_any   <= 1'b0;
         r_hit_idx   <= '0;
      end else begin
         r_s1_x      <= DrawX;
         r_s1_y      <= DrawY;
         r_s1_valid  <= pix_valid;
         r_rgb_valid <= r_s1_valid;
         if (!r_s1_valid) begin
            r_rgb     <= '0;
            r_hit_any <= 1'b0;
            r_hit_idx <= '0;
         end else if (w_hit_any) begin
            r_rgb     <= w_hit_color;
            r_hit_any <= 1'b1;
            r_hit_idx <= w_hit_idx;
         end else begin
            r_rgb     <= BG_RGB;
            r_hit_any <= 1'b0;
            r_hit_idx <= '0;
         end
      end
   end

   assign Red       = r_rgb[3*COLOR_W-1 -: COLOR_W];
   assign Green     = r_rgb[2*COLOR_W-1 -: COLOR_W];
   assign Blue      = r_rgb[COLOR_W-1:0];
   assign rgb_valid = r_rgb_valid;
   assign hit_any   = r_hit_any;
   assign hit_idx   = r_hit_idx;

endmodule

`default_nettype wire

// File: tb/tb_sprite_color_mapper.sv
// ============================================================================
// Module   : tb_sprite_color_mapper
// Purpose  : Directed, table-driven self-checking bench for sprite_color_mapper.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_color_mapper;

   localparam int NS = 6;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_idx = '0;
   logic [9:0]  wr_x = '0;
   logic [9:0]  wr_y = '0;
   logic [9:0]  wr_w = '0;
   logic [9:0]  wr_h = '0;
   logic [11:0] wr_color = '0;
   logic        wr_enable = 1'b0;
   logic        wr_blink = 1'b0;
   logic [3:0]  Red, Green, Blue;
   logic        rgb_valid, hit_any;
   logic [2:0]  hit_idx;
   logic [16:0] got;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt      = 0;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rgb;
      logic        hit;
      logic [2:0]  idx;
   } vec_t;

   vec_t tbl [14];

   sprite_color_mapper #(
      .NUM_SPRITES (NS),
      .BLINK_LOG2  (2)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_w        (wr_w),
      .wr_h        (wr_h),
      .wr_color    (wr_color),
      .wr_enable   (wr_enable),
      .wr_blink    (wr_blink),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .rgb_valid   (rgb_valid),
      .hit_any     (hit_any),
      .hit_idx     (hit_idx)
   );

   always #5 Clk = ~Clk;

   assign got = {rgb_valid, hit_any, hit_idx, Red, Green, Blue};

   task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {valid,hit,idx,rgb}=%h, expected %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                     input logic [9:0] w, input logic [9:0] h, input logic [11:0] c,
                     input logic en, input logic bl, input logic fs);
      @(negedge Clk);
      wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_w = w; wr_h = h;
      wr_color = c; wr_enable = en; wr_blink = bl; frame_start = fs;
      @(negedge Clk);
      wr_en = 1'b0; frame_start = 1'b0;
      if (fs) cnt = (cnt + 1) % 4;
   endtask

   task automatic frame();
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      cnt = (cnt + 1) % 4;
   endtask

   // One valid pixel, its result two edges later, then the blanked cycle after it.
   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [11:0] rgb,
                      input logic hit, input logic [2:0] idx, input string nm);
      @(negedge Clk);
      DrawX = x; DrawY = y; pix_valid = 1'b1;
      @(negedge Clk);
      pix_valid = 1'b0;
      @(negedge Clk);
      check(nm, got, {1'b1, hit, idx, rgb});
      @(negedge Clk);
      check({nm, "_blank"}, got, 17'h0);
   endtask

   initial begin
      logic        d1v, d2v, pv, spr_on, vis;
      logic [9:0]  d1x, d2x;
      logic [16:0] e;

      tbl[0]  = '{10'd150,  10'd150, 12'h0F0, 1'b1, 3'd2};
      tbl[1]  = '{10'd200,  10'd200, 12'h0F0, 1'b1, 3'd2};
      tbl[2]  = '{10'd201,  10'd150, 12'hF00, 1'b0, 3'd0};
      tbl[3]  = '{10'd100,  10'd100, 12'h0F0, 1'b1, 3'd2};
      tbl[4]  = '{10'd99,   10'd150, 12'hF00, 1'b0, 3'd0};
      tbl[5]  = '{10'd150,  10'd201, 12'hF00, 1'b0, 3'd0};
      tbl[6]  = '{10'd50,   10'd50,  12'h00F, 1'b1, 3'd1};
      tbl[7]  = '{10'd62,   10'd62,  12'hFFF, 1'b1, 3'd3};
      tbl[8]  = '{10'd1023, 10'd305, 12'h0A5, 1'b1, 3'd0};
      tbl[9]  = '{10'd1020, 10'd300, 12'h0A5, 1'b1, 3'd0};
      tbl[10] = '{10'd2,    10'd305, 12'hF00, 1'b0, 3'd0};
      tbl[11] = '{10'd1019, 10'd300, 12'hF00, 1'b0, 3'd0};
      tbl[12] = '{10'd500,  10'd505, 12'hF00, 1'b0, 3'd0};
      tbl[13] = '{10'd605,  10'd600, 12'hF00, 1'b0, 3'd0};

      repeat (2) @(negedge Clk);
      check("reset_outputs", got, 17'h0);
      Reset = 1'b0;

      pix(10'd150, 10'd150, 12'hF00, 1'b0, 3'd0, "bg_empty");
      wr(3'd2, 10'd100, 10'd100, 10'd101, 10'd101, 12'h0F0, 1'b1, 1'b0, 1'b0);
      pix(10'd150, 10'd150, 12'hF00, 1'b0, 3'd0, "shadow_only");
      frame();
      pix(10'd150, 10'd150, 12'h0F0, 1'b1, 3'd2, "after_swap");

      wr(3'd1, 10'd40,   10'd40,  10'd20, 10'd20, 12'h00F, 1'b1, 1'b0, 1'b0);
      wr(3'd3, 10'd45,   10'd45,  10'd20, 10'd20, 12'hFFF, 1'b1, 1'b0, 1'b0);
      wr(3'd0, 10'd1020, 10'd300, 10'd10, 10'd10, 12'h0A5, 1'b1, 1'b0, 1'b0);
      wr(3'd4, 10'd500,  10'd500, 10'd0,  10'd10, 12'h123, 1'b1, 1'b0, 1'b0);
      wr(3'd5, 10'd600,  10'd600, 10'd10, 10'd0,  12'h456, 1'b1, 1'b0, 1'b0);
      frame();
      for (int i = 0; i < 14; i++) begin
         pix(tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].hit, tbl[i].idx, $sformatf("tbl%0d", i));
      end

      wr(3'd1, 10'd40, 10'd40, 10'd20, 10'd20, 12'h00F, 1'b0, 1'b0, 1'b0);
      pix(10'd50, 10'd50, 12'h00F, 1'b1, 3'd1, "disable_pending");
      frame();
      pix(10'd50, 10'd50, 12'hFFF, 1'b1, 3'd3, "disable_swapped");

      wr(3'd6, 10'd0, 10'd0, 10'd1000, 10'd1000, 12'h555, 1'b1, 1'b0, 1'b0);
      wr(3'd7, 10'd0, 10'd0, 10'd1000, 10'd1000, 12'h555, 1'b1, 1'b0, 1'b1);
      pix(10'd300, 10'd300, 12'hF00, 1'b0, 3'd0, "bad_idx_bg");
      pix(10'd150, 10'd150, 12'h0F0, 1'b1, 3'd2, "bad_idx_keep");

      wr(3'd5, 10'd300, 10'd300, 10'd10, 10'd10, 12'hABC, 1'b1, 1'b0, 1'b1);
      pix(10'd305, 10'd305, 12'hABC, 1'b1, 3'd5, "wr_with_swap");

      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      cnt = 0;
      pix(10'd305, 10'd305, 12'hF00, 1'b0, 3'd0, "reset_clears_slots");
      pix(10'd150, 10'd150, 12'hF00, 1'b0, 3'd0, "reset_clears_slots2");

      wr(3'd0, 10'd10, 10'd10, 10'd10, 10'd10, 12'hF0F, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         vis = (cnt < 2);
         pix(10'd15, 10'd15, vis ? 12'hF0F : 12'hF00, vis, 3'd0, $sformatf("blink%0d", i));
         if (i < 4) frame();
      end

      DrawY  = 10'd15;
      spr_on = 1'b1;
      d1v = 1'b0; d2v = 1'b0; d1x = '0; d2x = '0;
      for (int x = 0; x < 640; x++) begin
         @(negedge Clk);
         if (!d2v)
            e = 17'h0;
         else if (spr_on && d2x >= 10 && d2x < 20)
            e = {1'b1, 1'b1, 3'd0, 12'hF0F};
         else
            e = {1'b1, 1'b0, 3'd0, 12'hF00};
         check($sformatf("stream%0d", x), got, e);
         if (x == 300) begin
            #2 Reset = 1'b1;
            #1 check("reset_async", got, 17'h0);
            d1v = 1'b0; d2v = 1'b0; spr_on = 1'b0;
         end
         if (x == 303) Reset = 1'b0;
         d2v = d1v; d2x = d1x;
         pv  = x[0] ^ x[3];
         d1v = pv && !Reset;
         d1x = 10'(x);
         DrawX = 10'(x);
         pix_valid = pv;
      end
      @(negedge Clk);
      pix_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
